jam_cost_table: RTL and testbench

- Cost-table front end for the job-assignment search engine.
- Accepts the 8x8 worker/job cost matrix as a 64-entry valid/ready stream and holds it in a register file.
- Serves the engine's `W`/`J` lookups combinationally with no wait states, and keeps the engine in reset until the table is complete.
- Captures the engine's final `MinCost`/`MatchCount` when it raises `Valid`, then presents them to the host.

---
 rtl/jam_cost_table_if.sv | 11 +
 rtl/jam_cost_table.sv | 113 +++++++++++
 tb/tb_jam_cost_table.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/jam_cost_table_if.sv
// Host cost-entry load stream (valid/ready) for jam_cost_table.
interface jam_cost_table_if #(
  parameter int COST_W = 7
);
  logic              IN_VALID;
  logic [COST_W-1:0] IN_DATA;
  logic              IN_READY;

  modport master (output IN_VALID, output IN_DATA, input IN_READY);
  modport slave  (input IN_VALID, input IN_DATA, output IN_READY);
endinterface

// File: rtl/jam_cost_table.sv
// Cost-table front end: loads an 8x8 cost matrix, holds the engine in reset until full,
// serves combinational W/J lookups and captures the engine result. Optional: COST_CHECKSUM_EN.
module jam_cost_table #(
  parameter int ENTRIES = 64,
  parameter int COST_W  = 7
) (
  input  logic              CLK,
  input  logic              RST_N,
  jam_cost_table_if.slave   host,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  output logic              JAM_RST,
  input  logic              Valid,
  input  logic [9:0]        MinCost,
  input  logic [3:0]        MatchCount,
  input  logic              RELOAD,
  output logic              RES_VALID,
  output logic [9:0]        RES_MINCOST,
  output logic [3:0]        RES_MATCHCOUNT,
  output logic [12:0]       CHECKSUM
);

  typedef enum logic [1:0] {S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [5:0]        wr_cnt_q, wr_cnt_d;
  logic              res_valid_q, res_valid_d;
  logic [9:0]        res_min_q, res_min_d;
  logic [3:0]        res_cnt_q, res_cnt_d;
  logic              wr_en;
  logic              reload_take;
  logic [COST_W-1:0] mem_q [ENTRIES];

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    res_valid_d = res_valid_q;
    res_min_d   = res_min_q;
    res_cnt_d   = res_cnt_q;
    wr_en       = 1'b0;
    reload_take = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (host.IN_VALID) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + 6'd1;
          if (wr_cnt_q == 6'(ENTRIES - 1)) state_d = S_HOLD;
        end
      end
      S_HOLD: state_d = S_RUN;
      S_RUN: begin
        if (Valid) begin
          res_min_d   = MinCost;
          res_cnt_d   = MatchCount;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // RELOAD wins over a concurrent Valid; results are only latched from RUN.
        if (RELOAD) begin
          reload_take = 1'b1;
          res_valid_d = 1'b0;
          wr_cnt_d    = '0;
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_LOAD;
      wr_cnt_q    <= '0;
      res_valid_q <= 1'b0;
      res_min_q   <= '0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      res_valid_q <= res_valid_d;
      res_min_q   <= res_min_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  // Table storage is deliberately not reset; a full reload always precedes RUN.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_cnt_q] <= host.IN_DATA;
  end

  assign host.IN_READY  = (state_q == S_LOAD);
  assign JAM_RST        = (state_q == S_LOAD) || (state_q == S_HOLD);
  assign Cost           = (state_q == S_LOAD) ? '0 : mem_q[{W, J}];
  assign RES_VALID      = res_valid_q;
  assign RES_MINCOST    = res_min_q;
  assign RES_MATCHCOUNT = res_cnt_q;

`ifdef COST_CHECKSUM_EN
  logic [12:0] sum_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)           sum_q <= '0;
    else if (reload_take) sum_q <= '0;
    else if (wr_en)       sum_q <= sum_q + 13'(host.IN_DATA);
  end
  assign CHECKSUM = sum_q;
`else
  assign CHECKSUM = '0;
`endif

endmodule

// File: tb/tb_jam_cost_table.sv
// Directed/randomized self-checking bench for jam_cost_table against a table-level model.
module tb_jam_cost_table;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] W, J;
  logic [6:0] Cost;
  logic       JAM_RST;
  logic       Valid;
  logic [9:0] MinCost;
  logic [3:0] MatchCount;
  logic       RELOAD;
  logic       RES_VALID;
  logic [9:0] RES_MINCOST;
  logic [3:0] RES_MATCHCOUNT;
  logic [12:0] CHECKSUM;

  jam_cost_table_if #(.COST_W(7)) host ();

  jam_cost_table #(.ENTRIES(64), .COST_W(7)) dut (
    .CLK(CLK), .RST_N(RST_N), .host(host), .W(W), .J(J), .Cost(Cost),
    .JAM_RST(JAM_RST), .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
    .RELOAD(RELOAD), .RES_VALID(RES_VALID), .RES_MINCOST(RES_MINCOST),
    .RES_MATCHCOUNT(RES_MATCHCOUNT), .CHECKSUM(CHECKSUM)
  );

  always #5 CLK = ~CLK;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: the table contents the host has written and the running entry sum.
  int model_mem [64];
  int model_sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int exp_checksum();
`ifdef COST_CHECKSUM_EN
    return model_sum;
`else
    return 0;
`endif
  endfunction

  // mode 0: (k%8)+1, mode 1: random, mode 2: all 127
  task automatic load_entries(input int n, input int mode, input bit stall);
    int acc = 0;
    int guard = 0;
    while (acc < n && guard < 2000) begin
      guard++;
      if (stall && ($urandom_range(0, 1) == 0)) begin
        host.IN_VALID = 1'b0;
        host.IN_DATA  = 7'($urandom);
      end else begin
        host.IN_VALID = 1'b1;
        host.IN_DATA  = (mode == 0) ? 7'((acc % 8) + 1) :
                        (mode == 1) ? 7'($urandom) : 7'd127;
      end
      #1;
      chk("load_ready", 32'(host.IN_READY), 32'd1);
      chk("load_jamrst", 32'(JAM_RST), 32'd1);
      chk("load_cost0", 32'(Cost), 32'd0);
      if (host.IN_VALID) begin
        model_mem[acc] = int'(host.IN_DATA);
        model_sum += int'(host.IN_DATA);
        acc++;
      end
      step();
    end
    if (acc < n) chk("load_timeout", 32'(acc), 32'(n));
    host.IN_VALID = 1'b0;
  endtask

  task automatic check_hold_then_run();
    chk("hold_ready", 32'(host.IN_READY), 32'd0);
    chk("hold_jamrst", 32'(JAM_RST), 32'd1);
    chk("hold_checksum", 32'(CHECKSUM), 32'(exp_checksum()));
    step();
    chk("run_jamrst", 32'(JAM_RST), 32'd0);
    chk("run_ready", 32'(host.IN_READY), 32'd0);
    chk("run_checksum", 32'(CHECKSUM), 32'(exp_checksum()));
  endtask

  task automatic random_lookups(input int n);
    for (int i = 0; i < n; i++) begin
      W = 3'($urandom);
      J = 3'($urandom);
      #1;
      chk("lookup", 32'(Cost), 32'(model_mem[int'(W) * 8 + int'(J)]));
    end
  endtask

  initial begin
    logic [9:0] mc;
    logic [3:0] cnt;
    RST_N = 1'b0; host.IN_VALID = 1'b0; host.IN_DATA = '0;
    W = '0; J = '0; Valid = 1'b0; MinCost = '0; MatchCount = '0; RELOAD = 1'b0;
    model_sum = 0;
    for (int i = 0; i < 64; i++) model_mem[i] = 0;
    step(); step();

    chk("rst_ready", 32'(host.IN_READY), 32'd1);
    chk("rst_jamrst", 32'(JAM_RST), 32'd1);
    chk("rst_cost", 32'(Cost), 32'd0);
    chk("rst_resvalid", 32'(RES_VALID), 32'd0);
    chk("rst_resmin", 32'(RES_MINCOST), 32'd0);
    chk("rst_rescnt", 32'(RES_MATCHCOUNT), 32'd0);
    chk("rst_checksum", 32'(CHECKSUM), 32'd0);
    RST_N = 1'b1;

    // Back-to-back load, lookups, capture.
    load_entries(64, 0, 1'b0);
    check_hold_then_run();
    W = 3'd3; J = 3'd5; #1;
    chk("lookup_w3j5", 32'(Cost), 32'd6);
    random_lookups(12);
    Valid = 1'b1; MinCost = 10'd300; MatchCount = 4'd2;
    step();
    MinCost = 10'd17; MatchCount = 4'd9;
    #1;
    chk("done_resvalid", 32'(RES_VALID), 32'd1);
    chk("done_resmin", 32'(RES_MINCOST), 32'd300);
    chk("done_rescnt", 32'(RES_MATCHCOUNT), 32'd2);
    chk("done_jamrst", 32'(JAM_RST), 32'd0);
    step();
    chk("frozen_resmin", 32'(RES_MINCOST), 32'd300);
    chk("frozen_rescnt", 32'(RES_MATCHCOUNT), 32'd2);
    Valid = 1'b0;

    // Reload from DONE.
    RELOAD = 1'b1;
    step();
    RELOAD = 1'b0;
    model_sum = 0;
    chk("reload_jamrst", 32'(JAM_RST), 32'd1);
    chk("reload_resvalid", 32'(RES_VALID), 32'd0);
    chk("reload_cost", 32'(Cost), 32'd0);
    chk("reload_ready", 32'(host.IN_READY), 32'd1);

    // Stalled random load with Valid/RELOAD asserted throughout LOAD (both ignored).
    Valid = 1'b1; MinCost = 10'd777; MatchCount = 4'd7; RELOAD = 1'b1;
    load_entries(64, 1, 1'b1);
    Valid = 1'b0; RELOAD = 1'b0;
    chk("ign_resvalid", 32'(RES_VALID), 32'd0);
    check_hold_then_run();
    RELOAD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ign_reload_run", 32'(JAM_RST), 32'd0);
      chk("ign_reload_resv", 32'(RES_VALID), 32'd0);
    end
    RELOAD = 1'b0;
    random_lookups(16);
    mc = 10'($urandom); cnt = 4'($urandom);
    Valid = 1'b1; MinCost = mc; MatchCount = cnt;
    step();
    chk("cap2_resvalid", 32'(RES_VALID), 32'd1);
    chk("cap2_resmin", 32'(RES_MINCOST), 32'(mc));
    chk("cap2_rescnt", 32'(RES_MATCHCOUNT), 32'(cnt));
    // Valid and RELOAD together in DONE: reload taken, no re-latch.
    MinCost = ~mc; MatchCount = ~cnt; RELOAD = 1'b1;
    step();
    Valid = 1'b0; RELOAD = 1'b0;
    model_sum = 0;
    chk("simul_resvalid", 32'(RES_VALID), 32'd0);
    chk("simul_jamrst", 32'(JAM_RST), 32'd1);
    chk("simul_resmin", 32'(RES_MINCOST), 32'(mc));
    chk("simul_rescnt", 32'(RES_MATCHCOUNT), 32'(cnt));

    // Reset mid-load, then a full load of 127s.
    load_entries(30, 1, 1'b0);
    RST_N = 1'b0;
    #2;
    model_sum = 0;
    chk("mid_rst_ready", 32'(host.IN_READY), 32'd1);
    chk("mid_rst_jamrst", 32'(JAM_RST), 32'd1);
    chk("mid_rst_resmin", 32'(RES_MINCOST), 32'd0);
    chk("mid_rst_rescnt", 32'(RES_MATCHCOUNT), 32'd0);
    chk("mid_rst_resvalid", 32'(RES_VALID), 32'd0);
    chk("mid_rst_checksum", 32'(CHECKSUM), 32'd0);
    step();
    RST_N = 1'b1;
    load_entries(64, 2, 1'b1);
`ifdef COST_CHECKSUM_EN
    chk("checksum_max", 32'(CHECKSUM), 32'd8128);
`else
    chk("checksum_off", 32'(CHECKSUM), 32'd0);
`endif
    check_hold_then_run();
    random_lookups(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
